mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 137 +++++++++++++
 tb/tb_mem_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Two-master data-BRAM arbiter: fixed priority with an m1 starvation guard by default,
// or a 1-bit round-robin pointer when MEM_ARB_RR_EN is defined.
module mem_arb #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_wea,
  input  logic [31:0] m0_wr_data,
  output logic        m0_gnt,
  output logic [31:0] m0_rd_data,
  output logic        m0_rd_valid,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_wea,
  input  logic [31:0] m1_wr_data,
  output logic        m1_gnt,
  output logic [31:0] m1_rd_data,
  output logic        m1_rd_valid,
  output logic        cpu_stall,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wea,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned CW = 8;

  logic          g0;
  logic          g1;
  logic          ret_valid;
  logic          ret_owner;
  logic [DW-1:0] hold0;
  logic [DW-1:0] hold1;

`ifdef MEM_ARB_RR_EN
  logic ptr;

  // Pointer's master wins on contention; a lone requester always wins.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        g0 = ~ptr;
        g1 = ptr;
      end else begin
        g0 = m0_req;
        g1 = m1_req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ptr <= 1'b0;
    else if (g0) ptr <= 1'b1;
    else if (g1) ptr <= 1'b0;
  end
`else
  logic [CW-1:0] starve;
  logic          force1;

  assign force1 = (starve == CW'(STARVE_LIMIT));

  // m0 has priority unless m1 has been denied STARVE_LIMIT cycles in a row.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (m1_req && (!m0_req || force1)) g1 = 1'b1;
      else if (m0_req)                   g0 = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          starve <= '0;
    else if (!m1_req || g1)           starve <= '0;
    else if (starve != {CW{1'b1}})    starve <= starve + CW'(1);
  end
`endif

  // One outstanding read return, tagged with the master that issued it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_valid <= 1'b0;
      ret_owner <= 1'b0;
    end else begin
      ret_valid <= (g0 && (m0_wea == BW'(0))) || (g1 && (m1_wea == BW'(0)));
      ret_owner <= g1;
    end
  end

  assign m0_rd_valid = ret_valid && !ret_owner;
  assign m1_rd_valid = ret_valid && ret_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (m0_rd_valid) hold0 <= mem_rd_data;
      if (m1_rd_valid) hold1 <= mem_rd_data;
    end
  end

  assign m0_rd_data = m0_rd_valid ? mem_rd_data : hold0;
  assign m1_rd_data = m1_rd_valid ? mem_rd_data : hold1;

  // BRAM port mux; everything reads as zero when idle.
  always_comb begin
    mem_en      = 1'b0;
    mem_addr    = '0;
    mem_wea     = '0;
    mem_wr_data = '0;
    if (g0) begin
      mem_en      = 1'b1;
      mem_addr    = m0_addr;
      mem_wea     = m0_wea;
      mem_wr_data = m0_wr_data;
    end else if (g1) begin
      mem_en      = 1'b1;
      mem_addr    = m1_addr;
      mem_wea     = m1_wea;
      mem_wr_data = m1_wr_data;
    end
  end

  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign cpu_stall = !rst && m0_req && !g0;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed vector table, contention sequence,
// then randomized traffic against a behavioural model.
module tb_mem_arb;

  localparam int unsigned LIMIT = 8;

  logic        clk;
  logic        rst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wr_data, m1_wr_data;
  logic [3:0]  m0_wea, m1_wea;
  logic        m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic        cpu_stall, mem_en;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [3:0]  mem_wea;

  int checks = 0;
  int errors = 0;

  mem_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wea(m0_wea), .m0_wr_data(m0_wr_data),
    .m0_gnt(m0_gnt), .m0_rd_data(m0_rd_data), .m0_rd_valid(m0_rd_valid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wea(m1_wea), .m1_wr_data(m1_wr_data),
    .m1_gnt(m1_gnt), .m1_rd_data(m1_rd_data), .m1_rd_valid(m1_rd_valid),
    .cpu_stall(cpu_stall), .mem_en(mem_en), .mem_addr(mem_addr), .mem_wea(mem_wea),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        r0;
    logic [31:0] a0;
    logic [3:0]  w0;
    logic [31:0] d0;
    logic        r1;
    logic [31:0] a1;
    logic [3:0]  w1;
    logic [31:0] d1;
    logic [31:0] mrd;
  } in_t;

  typedef struct {
    logic        g0;
    logic        g1;
    logic        stall;
    logic        en;
    logic [31:0] addr;
    logic [3:0]  wea;
    logic [31:0] wd;
    logic        v0;
    logic [31:0] rd0;
    logic        v1;
    logic [31:0] rd1;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  // Reference model state
  int          streak;
  bit          ptr;
  bit          pend;
  bit          pend_m1;
  logic [31:0] hold [2];

  function automatic in_t mi(logic r, logic r0, logic [31:0] a0, logic [3:0] w0, logic [31:0] d0,
                             logic r1, logic [31:0] a1, logic [3:0] w1, logic [31:0] d1,
                             logic [31:0] mrd);
    in_t x;
    x.rst = r; x.r0 = r0; x.a0 = a0; x.w0 = w0; x.d0 = d0;
    x.r1 = r1; x.a1 = a1; x.w1 = w1; x.d1 = d1; x.mrd = mrd;
    return x;
  endfunction

  function automatic out_t mo(logic g0, logic g1, logic st, logic en, logic [31:0] addr,
                              logic [3:0] wea, logic [31:0] wd, logic v0, logic [31:0] rd0,
                              logic v1, logic [31:0] rd1);
    out_t o;
    o.g0 = g0; o.g1 = g1; o.stall = st; o.en = en; o.addr = addr; o.wea = wea;
    o.wd = wd; o.v0 = v0; o.rd0 = rd0; o.v1 = v1; o.rd1 = rd1;
    return o;
  endfunction

  task automatic model_cycle(input in_t x, output out_t e);
    if (x.rst) begin
      streak = 0; ptr = 0; pend = 0; pend_m1 = 0; hold[0] = '0; hold[1] = '0;
    end
    e.g0 = 1'b0;
    e.g1 = 1'b0;
    if (!x.rst) begin
      if (x.r0 && x.r1) begin
`ifdef MEM_ARB_RR_EN
        if (ptr) e.g1 = 1'b1; else e.g0 = 1'b1;
`else
        if (streak == int'(LIMIT)) e.g1 = 1'b1; else e.g0 = 1'b1;
`endif
      end else begin
        e.g0 = x.r0;
        e.g1 = x.r1;
      end
    end
    e.stall = !x.rst && x.r0 && !e.g0;
    e.en    = e.g0 || e.g1;
    e.addr  = e.g0 ? x.a0 : (e.g1 ? x.a1 : 32'h0);
    e.wea   = e.g0 ? x.w0 : (e.g1 ? x.w1 : 4'h0);
    e.wd    = e.g0 ? x.d0 : (e.g1 ? x.d1 : 32'h0);
    e.v0    = !x.rst && pend && !pend_m1;
    e.v1    = !x.rst && pend && pend_m1;
    e.rd0   = e.v0 ? x.mrd : hold[0];
    e.rd1   = e.v1 ? x.mrd : hold[1];
    if (!x.rst) begin
      if (e.v0) hold[0] = x.mrd;
      if (e.v1) hold[1] = x.mrd;
      pend    = (e.g0 && x.w0 == 4'h0) || (e.g1 && x.w1 == 4'h0);
      pend_m1 = e.g1;
      if (!x.r1 || e.g1) streak = 0;
      else if (streak < 255) streak = streak + 1;
      if (e.g0) ptr = 1;
      else if (e.g1) ptr = 0;
    end
  endtask

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input out_t e);
    cmp({tag, ".m0_gnt"},      32'(m0_gnt),      32'(e.g0));
    cmp({tag, ".m1_gnt"},      32'(m1_gnt),      32'(e.g1));
    cmp({tag, ".cpu_stall"},   32'(cpu_stall),   32'(e.stall));
    cmp({tag, ".mem_en"},      32'(mem_en),      32'(e.en));
    cmp({tag, ".mem_addr"},    mem_addr,         e.addr);
    cmp({tag, ".mem_wea"},     32'(mem_wea),     32'(e.wea));
    cmp({tag, ".mem_wr_data"}, mem_wr_data,      e.wd);
    cmp({tag, ".m0_rd_valid"}, 32'(m0_rd_valid), 32'(e.v0));
    cmp({tag, ".m0_rd_data"},  m0_rd_data,       e.rd0);
    cmp({tag, ".m1_rd_valid"}, 32'(m1_rd_valid), 32'(e.v1));
    cmp({tag, ".m1_rd_data"},  m1_rd_data,       e.rd1);
  endtask

  // Drive one cycle's inputs after the edge, sample mid-cycle, advance the model.
  task automatic apply(input in_t x, output out_t e);
    @(posedge clk);
    #1;
    rst = x.rst;
    m0_req = x.r0; m0_addr = x.a0; m0_wea = x.w0; m0_wr_data = x.d0;
    m1_req = x.r1; m1_addr = x.a1; m1_wea = x.w1; m1_wr_data = x.d1;
    mem_rd_data = x.mrd;
    @(negedge clk);
    model_cycle(x, e);
  endtask

  vec_t  vecs [12];
  in_t   x;
  out_t  e;
  logic  pg0, pg1;
  logic  exp1, prev1;

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_addr = 0; m0_wea = 0; m0_wr_data = 0;
    m1_req = 0; m1_addr = 0; m1_wea = 0; m1_wr_data = 0;
    mem_rd_data = 0;
    streak = 0; ptr = 0; pend = 0; pend_m1 = 0; hold[0] = '0; hold[1] = '0;

    vecs[0]  = '{mi(1, 1, 32'h10, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0),
                 mo(0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 0, 32'h0)};
    vecs[1]  = '{mi(0, 1, 32'h10, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0),
                 mo(1, 0, 0, 1, 32'h10, 4'h0, 32'h0, 0, 32'h0, 0, 32'h0)};
    vecs[2]  = '{mi(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF),
                 mo(0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'hDEADBEEF, 0, 32'h0)};
    vecs[3]  = '{mi(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h12345678),
                 mo(0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 32'hDEADBEEF, 0, 32'h0)};
    vecs[4]  = '{mi(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h20, 4'h3, 32'h0000BEEF, 32'h0),
                 mo(0, 1, 0, 1, 32'h20, 4'h3, 32'h0000BEEF, 0, 32'hDEADBEEF, 0, 32'h0)};
    vecs[5]  = '{mi(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'hAAAA5555),
                 mo(0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 32'hDEADBEEF, 0, 32'h0)};
    vecs[6]  = '{mi(0, 1, 32'h44, 4'h0, 32'h99, 0, 32'h0, 4'h0, 32'h0, 32'h0),
                 mo(1, 0, 0, 1, 32'h44, 4'h0, 32'h99, 0, 32'hDEADBEEF, 0, 32'h0)};
    vecs[7]  = '{mi(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h48, 4'h0, 32'h0, 32'hCAFEF00D),
                 mo(0, 1, 0, 1, 32'h48, 4'h0, 32'h0, 1, 32'hCAFEF00D, 0, 32'h0)};
    vecs[8]  = '{mi(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0BADF00D),
                 mo(0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 32'hCAFEF00D, 1, 32'h0BADF00D)};
    vecs[9]  = '{mi(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h50, 4'h0, 32'h0, 32'h0),
                 mo(0, 1, 0, 1, 32'h50, 4'h0, 32'h0, 0, 32'hCAFEF00D, 0, 32'h0BADF00D)};
    vecs[10] = '{mi(1, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h11112222),
                 mo(0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 0, 32'h0)};
    vecs[11] = '{mi(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h33334444),
                 mo(0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 0, 32'h0)};

    for (int k = 0; k < 12; k++) begin
      apply(vecs[k].i, e);
      cmp_all($sformatf("vec%0d", k), vecs[k].o);
    end

    // Continuous contention from reset.
    apply(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), e);
    prev1 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      apply(mi(0, 1, 32'(i * 4), 4'h0, 32'h0, 1, 32'h100, 4'h0, 32'h0, 32'(i)), e);
`ifdef MEM_ARB_RR_EN
      exp1 = (i % 2 == 0);
`else
      exp1 = (i % (int'(LIMIT) + 1) == 0);
`endif
      cmp($sformatf("cont%0d.m0_gnt", i),      32'(m0_gnt),      32'(!exp1));
      cmp($sformatf("cont%0d.m1_gnt", i),      32'(m1_gnt),      32'(exp1));
      cmp($sformatf("cont%0d.cpu_stall", i),   32'(cpu_stall),   32'(exp1));
      cmp($sformatf("cont%0d.m1_rd_valid", i), 32'(m1_rd_valid), 32'(prev1));
      prev1 = exp1;
    end

    // Randomized traffic; a master keeps its request stable until granted.
    x = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pg0 = 1'b0;
    pg1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!x.r0 || pg0) begin
        x.r0 = ($urandom_range(0, 7) != 0);
        x.a0 = $urandom;
        x.w0 = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        x.d0 = $urandom;
      end
      if (!x.r1 || pg1) begin
        x.r1 = ($urandom_range(0, 2) == 0);
        x.a1 = $urandom;
        x.w1 = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        x.d1 = $urandom;
      end
      x.mrd = $urandom;
      x.rst = ($urandom_range(0, 199) == 0);
      apply(x, e);
      cmp_all("rnd", e);
      pg0 = e.g0;
      pg1 = e.g1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
